// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: serial ALU request receiver.
// Frames are 11 bits (start, type, 8 payload MSB first, stop). A request is
// eight data frames (B then A, MSB byte first) plus one cmd frame carrying
// {1'b0, OP, CRC}. The request is either accepted (out_valid) or rejected
// (err_valid + err_flags).
// Build option: define MTM_ALU_DESER_CRC_EN to enable the CRC-4 check;
// without it no CRC logic is built and the received CRC bits are ignored.
module mtm_alu_deserializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic [31:0] b_data,
    output logic [31:0] a_data,
    output logic [2:0]  op,
    output logic        out_valid,
    output logic        err_valid,
    output logic [2:0]  err_flags
);

    typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD, STOP} state_t;

    localparam logic [2:0] ERR_DATA = 3'b100;
    localparam logic [2:0] ERR_CRC  = 3'b010;
    localparam logic [2:0] ERR_OP   = 3'b001;

    state_t      state_q;
    logic        type_q;       // 1 = cmd frame
    logic [2:0]  bitcnt_q;
    logic [7:0]  byte_q;
    logic [63:0] shreg_q;      // {B, A}
    logic [3:0]  dcnt_q;       // data frames in current request, saturates at 9
    logic        ferr_q;       // sticky stop-bit error for current request
    logic [31:0] b_data_q, a_data_q;
    logic [2:0]  op_q, err_flags_q;
    logic        out_valid_q, err_valid_q;

    logic [2:0]  err_code_d;

`ifdef MTM_ALU_DESER_CRC_EN
    // Serial CRC-4, x^4+x+1, init 0, MSB first.
    function automatic logic [3:0] crc4(input logic [67:0] v);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ v[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    logic crc_bad;
    assign crc_bad = (crc4({shreg_q, 1'b1, byte_q[6:4]}) != byte_q[3:0]);
`endif

    // Verdict for a cmd frame whose stop bit is on sin this cycle; the stop
    // bit itself counts toward the frame-error condition.
    always_comb begin
        err_code_d = 3'b000;
        if (dcnt_q != 4'd8 || ferr_q || !sin)
            err_code_d = ERR_DATA;
`ifdef MTM_ALU_DESER_CRC_EN
        else if (crc_bad)
            err_code_d = ERR_CRC;
`endif
        else if (byte_q[5])    // OP[1] set -> opcode outside {000,001,100,101}
            err_code_d = ERR_OP;
    end

    // Frame FSM, request bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            type_q      <= 1'b0;
            bitcnt_q    <= 3'd0;
            byte_q      <= 8'h00;
            shreg_q     <= 64'h0;
            dcnt_q      <= 4'd0;
            ferr_q      <= 1'b0;
            b_data_q    <= 32'h0;
            a_data_q    <= 32'h0;
            op_q        <= 3'b000;
            err_flags_q <= 3'b000;
            out_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!sin) state_q <= TYPE;
                end
                TYPE: begin
                    type_q   <= sin;
                    bitcnt_q <= 3'd0;
                    state_q  <= PAYLOAD;
                end
                PAYLOAD: begin
                    byte_q   <= {byte_q[6:0], sin};
                    bitcnt_q <= bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_q <= STOP;
                end
                STOP: begin
                    state_q <= IDLE;
                    if (!type_q) begin
                        shreg_q <= {shreg_q[55:0], byte_q};
                        if (dcnt_q != 4'd9) dcnt_q <= dcnt_q + 4'd1;
                        if (!sin) ferr_q <= 1'b1;
                    end else begin
                        // Request ends here whatever the verdict.
                        dcnt_q <= 4'd0;
                        ferr_q <= 1'b0;
                        if (err_code_d == 3'b000) begin
                            b_data_q    <= shreg_q[63:32];
                            a_data_q    <= shreg_q[31:0];
                            op_q        <= byte_q[6:4];
                            out_valid_q <= 1'b1;
                        end else begin
                            err_flags_q <= err_code_d;
                            err_valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign b_data    = b_data_q;
    assign a_data    = a_data_q;
    assign op        = op_q;
    assign out_valid = out_valid_q;
    assign err_valid = err_valid_q;
    assign err_flags = err_flags_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for mtm_alu_deserializer. Inputs change on the falling
// edge; outputs are sampled on the falling edge. A monitor counts
// out_valid / err_valid cycles so each scenario can check pulse counts.
module tb_mtm_alu_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sin;
    logic [31:0] b_data, a_data;
    logic [2:0]  op, err_flags;
    logic        out_valid, err_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int n_err   = 0;
    int n_both  = 0;

    always #5 clk = ~clk;

    mtm_alu_deserializer dut (
        .clk(clk), .rst(rst), .sin(sin),
        .b_data(b_data), .a_data(a_data), .op(op),
        .out_valid(out_valid), .err_valid(err_valid), .err_flags(err_flags)
    );

    always @(negedge clk) begin
        if (out_valid) n_out++;
        if (err_valid) n_err++;
        if (out_valid && err_valid) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC by polynomial long division of {B,A,1,OP} * x^4 by 10011.
    function automatic logic [3:0] crc_ref(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] o);
        logic [71:0] m;
        m = {b, a, 1'b1, o, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (m[i]) m[i-:5] = m[i-:5] ^ 5'b10011;
        return m[3:0];
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk) sin = b;
    endtask

    task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    // ndata data frames (bytes of {B,A} from the top, 8'h55 past eight),
    // bad_stop = 1-based index of a data frame sent with stop bit 0 (0: none),
    // then the cmd frame, then a short idle.
    task automatic send_req(input logic [31:0] b, input logic [31:0] a, input logic [2:0] o,
                            input logic [3:0] crc, input int ndata, input int bad_stop);
        logic [63:0] dat;
        logic [7:0]  by;
        dat = {b, a};
        for (int i = 0; i < ndata; i++) begin
            by = (i < 8) ? dat[63 - 8*i -: 8] : 8'h55;
            send_frame(1'b0, by, (i + 1 == bad_stop) ? 1'b0 : 1'b1);
        end
        send_frame(1'b1, {1'b0, o, crc}, 1'b1);
        idle(3);
    endtask

    int o0, e0;

    initial begin
        rst = 1'b1;
        sin = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_b_data", b_data, 32'h0);
        chk("rst_a_data", a_data, 32'h0);
        chk("rst_op", {29'd0, op}, 32'h0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("rst_err_valid", {31'd0, err_valid}, 32'h0);
        chk("rst_err_flags", {29'd0, err_flags}, 32'h0);
        rst = 1'b0;
        idle(5);
        chk("idle_no_pulse", n_out + n_err, 0);

        // S1: valid request; CRC 4'hC worked out by hand.
        o0 = n_out; e0 = n_err;
        send_req(32'h0000_0002, 32'h0000_0001, 3'b100, 4'hC, 8, 0);
        chk("s1_out_cnt", n_out - o0, 1);
        chk("s1_err_cnt", n_err - e0, 0);
        chk("s1_b_data", b_data, 32'h0000_0002);
        chk("s1_a_data", a_data, 32'h0000_0001);
        chk("s1_op", {29'd0, op}, 32'h4);

        // S2: same request with corrupted CRC.
        o0 = n_out; e0 = n_err;
        send_req(32'h0000_0002, 32'h0000_0001, 3'b100, 4'hC ^ 4'h1, 8, 0);
`ifdef MTM_ALU_DESER_CRC_EN
        chk("s2_err_cnt", n_err - e0, 1);
        chk("s2_out_cnt", n_out - o0, 0);
        chk("s2_err_flags", {29'd0, err_flags}, 32'h2);
`else
        chk("s2_out_cnt", n_out - o0, 1);
        chk("s2_err_cnt", n_err - e0, 0);
`endif
        chk("s2_b_data", b_data, 32'h0000_0002);

        // S3: seven data frames, then a full valid request.
        o0 = n_out; e0 = n_err;
        send_req(32'h1111_2222, 32'h3333_4444, 3'b001,
                 crc_ref(32'h1111_2222, 32'h3333_4444, 3'b001), 7, 0);
        chk("s3_err_cnt", n_err - e0, 1);
        chk("s3_out_cnt", n_out - o0, 0);
        chk("s3_err_flags", {29'd0, err_flags}, 32'h4);
        chk("s3_b_kept", b_data, 32'h0000_0002);
        o0 = n_out; e0 = n_err;
        send_req(32'h1111_2222, 32'h3333_4444, 3'b001,
                 crc_ref(32'h1111_2222, 32'h3333_4444, 3'b001), 8, 0);
        chk("s3b_out_cnt", n_out - o0, 1);
        chk("s3b_err_cnt", n_err - e0, 0);
        chk("s3b_a_data", a_data, 32'h3333_4444);
        chk("s3b_op", {29'd0, op}, 32'h1);
        chk("s3b_flags_held", {29'd0, err_flags}, 32'h4);

        // S4: illegal opcode.
        o0 = n_out; e0 = n_err;
        send_req(32'hFFFF_FFFF, 32'h8000_0000, 3'b011,
                 crc_ref(32'hFFFF_FFFF, 32'h8000_0000, 3'b011), 8, 0);
        chk("s4_err_cnt", n_err - e0, 1);
        chk("s4_out_cnt", n_out - o0, 0);
        chk("s4_err_flags", {29'd0, err_flags}, 32'h1);

        // S5: bad stop bit on 3rd data frame.
        o0 = n_out; e0 = n_err;
        send_req(32'h0000_0002, 32'h0000_0001, 3'b100, 4'hC, 8, 3);
        chk("s5_err_cnt", n_err - e0, 1);
        chk("s5_err_flags", {29'd0, err_flags}, 32'h4);

        // Nine data frames: oldest byte lost, ERR_DATA.
        o0 = n_out; e0 = n_err;
        send_req(32'h0000_0002, 32'h0000_0001, 3'b100, 4'hC, 9, 0);
        chk("s9_err_cnt", n_err - e0, 1);
        chk("s9_out_cnt", n_out - o0, 0);
        chk("s9_err_flags", {29'd0, err_flags}, 32'h4);

        // S6: reset in payload of 5th data frame, then valid request.
        o0 = n_out; e0 = n_err;
        send_frame(1'b0, 8'h9A, 1'b1);
        send_frame(1'b0, 8'hBC, 1'b1);
        send_frame(1'b0, 8'hDE, 1'b1);
        send_frame(1'b0, 8'hF0, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        @(negedge clk) begin rst = 1'b1; sin = 1'b1; end
        @(negedge clk) rst = 1'b0;
        idle(3);
        chk("s6_rst_no_pulse", (n_out - o0) + (n_err - e0), 0);
        chk("s6_rst_b_data", b_data, 32'h0);
        chk("s6_rst_err_flags", {29'd0, err_flags}, 32'h0);
        o0 = n_out; e0 = n_err;
        send_req(32'h9ABC_DEF0, 32'h1234_5678, 3'b000,
                 crc_ref(32'h9ABC_DEF0, 32'h1234_5678, 3'b000), 8, 0);
        chk("s6_out_cnt", n_out - o0, 1);
        chk("s6_err_cnt", n_err - e0, 0);
        chk("s6_b_data", b_data, 32'h9ABC_DEF0);
        chk("s6_a_data", a_data, 32'h1234_5678);
        chk("s6_op", {29'd0, op}, 32'h0);

        chk("never_both_pulses", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mtm_alu_deserializer.md
MTM_ALU_DESERIALIZER -- requirements
Module: mtm_alu_deserializer

Interface
REQ-001 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all logic on the rising edge
- rst  input  1  reset, synchronous, active-high
- sin  input  1  serial ALU request line, idle high, one bit per clk
- b_data  output  32  operand B of the last accepted request
- a_data  output  32  operand A of the last accepted request
- op  output  3  opcode of the last accepted request
- out_valid  output  1  one-cycle pulse: a request was accepted
- err_valid  output  1  one-cycle pulse: a request was rejected
- err_flags  output  3  error code, valid with err_valid: {ERR_DATA, ERR_CRC, ERR_OP}
REQ-002 The block SHALL have no parameters; widths are fixed.

Function
REQ-003 Frame format SHALL be 11 bits, sampled one bit per clk: start bit 0, type bit (0 = data, 1 = cmd), 8 payload bits MSB first, stop bit 1.
REQ-004 Request format SHALL be 8 data frames (B[31:24]..B[7:0], then A[31:24]..A[7:0]) followed by one cmd frame with payload {1'b0, OP[2:0], CRC[3:0]}.
REQ-005 The FSM SHALL have states IDLE, TYPE, PAYLOAD and STOP:
- IDLE->TYPE when sin==0
- TYPE->PAYLOAD after 1 cycle, type latched
- PAYLOAD->STOP after 8 cycles (3-bit bit counter)
- STOP->IDLE after 1 cycle
REQ-006 In STOP, a data frame SHALL shift its byte into a 64-bit {B,A} shift register and increment a data-frame counter saturating at 9.
REQ-007 In STOP, sin==0 SHALL set a sticky frame-error flag for the current request; the FSM still returns to IDLE.
REQ-008 In STOP of a cmd frame, the block SHALL evaluate the request, with priority:
- ERR_DATA (3'b100) if data-frame counter != 8 or frame-error flag set
- else ERR_CRC (3'b010) if received CRC != computed CRC
- else ERR_OP (3'b001) if OP is not one of 000, 001, 100, 101
- else accept
REQ-009 The computed CRC SHALL be CRC-4 (polynomial x^4+x+1, init 4'h0) over the 68-bit vector {B, A, 1'b1, OP}, MSB first.
REQ-010 On accept, the block SHALL load b_data, a_data and op and pulse out_valid; on reject, it SHALL pulse err_valid with err_flags and leave b_data, a_data and op unchanged.
REQ-011 out_valid and err_valid SHALL pulse for exactly one cycle, the cycle after the cmd stop bit is sampled; they are never asserted together.
REQ-012 err_flags SHALL hold its value until the next err_valid.
REQ-013 After each cmd frame (accepted or rejected), the data-frame counter and frame-error flag SHALL clear, so the next frame starts a new request.
REQ-014 sin held at 1 in IDLE SHALL cause no state change, for any duration.
REQ-015 A 9th or later data frame before the cmd frame SHALL be shifted in (oldest byte lost) and SHALL force ERR_DATA at the cmd frame.
REQ-016 A new start bit SHALL be accepted in the cycle immediately after STOP (back-to-back frames, no idle gap required).

Reset
REQ-017 When rst is high at a clk edge, the block SHALL enter IDLE and clear b_data, a_data, op, err_flags, out_valid, err_valid, the shift register, all counters and the frame-error flag to 0.
REQ-018 Reset asserted mid-frame or mid-request SHALL discard the partial request; no pulse SHALL be generated for it.

Configuration
REQ-019 With macro MTM_ALU_DESER_CRC_EN defined, the block SHALL perform the CRC check of REQ-008/009.
REQ-020 With MTM_ALU_DESER_CRC_EN undefined, the block SHALL contain no CRC logic, SHALL never report ERR_CRC, and SHALL ignore the received CRC bits; all other checks are unchanged.

Verification
REQ-021 The bench SHALL cover the following directed scenarios (stimulus -> required response):
- B=32'h0000_0002, A=32'h0000_0001, OP=3'b100, correct CRC -> out_valid 1 cycle, b_data=2, a_data=1, op=3'b100, err_valid=0
- Same request with CRC XOR 4'h1 -> err_valid with err_flags=3'b010 (CRC_EN defined); out_valid with same request (CRC_EN undefined)
- Only 7 data frames then a valid cmd -> err_flags=3'b100; the next full valid request -> out_valid
- B=32'hFFFF_FFFF, A=32'h8000_0000, OP=3'b011, correct CRC -> err_flags=3'b011 not allowed; err_flags=3'b001 exactly
- Stop bit 0 on the 3rd data frame, otherwise valid -> err_flags=3'b100
- rst pulsed during the payload of the 5th data frame, then a full valid request (A=32'h1234_5678, B=32'h9ABC_DEF0, OP=3'b000) -> exactly one out_valid, with those values
